// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch stage: pre-IF request bundle,
// exception record, pipeline flush causes and the bundle handed to decode.
package if_stage_pkg;

  typedef struct packed {
    logic        ex;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
  } exception_t;

  typedef struct packed {
    logic ex;
    logic eret;
    logic tlb_op;
    logic cache_op;
  } pipeline_flush_t;

  typedef struct packed {
    logic        valid;
    logic        req_sent;
    logic        br_op;
    logic [31:0] pc;
    exception_t  exception;
  } pfs_to_fs_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br_op;
    exception_t  exception;
  } fs_to_ds_bus_t;

  function automatic logic flush_req(input pipeline_flush_t pf, input logic bpu);
    return pf.ex | pf.eret | pf.tlb_op | pf.cache_op | bpu;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds one slot, waits for the in-order icache beat,
// buffers it while decode stalls and discards beats belonging to flushed requests.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int DISCARD_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  pfs_to_fs_bus_t  pfs_to_fs_bus,
  output logic            fs_allowin,
  output logic            fs_valid,
  input  pipeline_flush_t pipeline_flush,
  input  logic            bpu_flush,
  input  logic            icache_data_ok,
  input  logic [31:0]     icache_rdata,
  input  logic            ds_allowin,
  output logic            fs_to_ds_valid,
  output fs_to_ds_bus_t   fs_to_ds_bus
);

  localparam int SW = DISCARD_W + 2;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << DISCARD_W) - 1);

  logic                 fs_valid_q, fs_valid_d;
  logic [31:0]          fs_pc_q, fs_pc_d;
  logic                 fs_br_op_q, fs_br_op_d;
  logic                 fs_req_sent_q, fs_req_sent_d;
  exception_t           fs_exception_q, fs_exception_d;
  logic [31:0]          inst_buf_q, inst_buf_d;
  logic                 inst_buf_valid_q, inst_buf_valid_d;
  logic [DISCARD_W-1:0] discard_cnt_q, discard_cnt_d;

  logic          flush;
  logic          resp_ok;
  logic          drop;
  logic          fs_ready_go;
  logic          slot_waiting;
  logic          new_req;
  logic [SW-1:0] cnt_sum;

  assign flush       = flush_req(pipeline_flush, bpu_flush);
  assign resp_ok     = icache_data_ok && (discard_cnt_q == '0);
  assign drop        = icache_data_ok && (discard_cnt_q != '0);
  assign fs_ready_go = fs_exception_q.ex | inst_buf_valid_q | resp_ok;

  assign fs_allowin     = !fs_valid_q | (fs_ready_go & ds_allowin);
  assign fs_valid       = fs_valid_q;
  assign fs_to_ds_valid = fs_valid_q & fs_ready_go & !flush;

  // A beat consumed in the flush cycle is not still in flight, so it is not counted.
  assign slot_waiting = fs_valid_q & fs_req_sent_q & !inst_buf_valid_q & !resp_ok;
  assign new_req      = pfs_to_fs_bus.valid & pfs_to_fs_bus.req_sent & fs_allowin;

  assign cnt_sum = SW'(discard_cnt_q)
                 + (flush ? (SW'(slot_waiting) + SW'(new_req)) : '0)
                 - SW'(drop);
  assign discard_cnt_d = (cnt_sum > CNT_MAX) ? CNT_MAX[DISCARD_W-1:0] : cnt_sum[DISCARD_W-1:0];

  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    fs_br_op_d       = fs_br_op_q;
    fs_req_sent_d    = fs_req_sent_q;
    fs_exception_d   = fs_exception_q;
    inst_buf_d       = inst_buf_q;
    inst_buf_valid_d = inst_buf_valid_q;

    if (flush) begin
      fs_valid_d       = 1'b0;
      inst_buf_valid_d = 1'b0;
    end else if (fs_allowin) begin
      fs_valid_d       = pfs_to_fs_bus.valid;
      fs_pc_d          = pfs_to_fs_bus.pc;
      fs_br_op_d       = pfs_to_fs_bus.br_op;
      fs_req_sent_d    = pfs_to_fs_bus.req_sent;
      fs_exception_d   = pfs_to_fs_bus.exception;
      inst_buf_valid_d = 1'b0;
    end else if (resp_ok && fs_valid_q && !ds_allowin) begin
      inst_buf_d       = icache_rdata;
      inst_buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= '0;
      fs_br_op_q       <= 1'b0;
      fs_req_sent_q    <= 1'b0;
      fs_exception_q   <= '0;
      inst_buf_q       <= '0;
      inst_buf_valid_q <= 1'b0;
      discard_cnt_q    <= '0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      fs_br_op_q       <= fs_br_op_d;
      fs_req_sent_q    <= fs_req_sent_d;
      fs_exception_q   <= fs_exception_d;
      inst_buf_q       <= inst_buf_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      discard_cnt_q    <= discard_cnt_d;
    end
  end

  // Empty or faulting slots present a zero word rather than whatever is on the icache bus.
  always_comb begin
    fs_to_ds_bus           = '0;
    fs_to_ds_bus.pc        = fs_pc_q;
    fs_to_ds_bus.br_op     = fs_br_op_q;
    fs_to_ds_bus.exception = fs_exception_q;
    if (fs_valid_q && !fs_exception_q.ex)
      fs_to_ds_bus.inst = inst_buf_valid_q ? inst_buf_q : icache_rdata;
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then random
// traffic checked each cycle against a request-tracking model of fetch.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [4:0] EXC_ADEL = 5'h04;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  pfs_to_fs_bus_t  pfs_to_fs_bus = '0;
  logic            fs_allowin;
  logic            fs_valid;
  pipeline_flush_t pipeline_flush = '0;
  logic            bpu_flush = 1'b0;
  logic            icache_data_ok = 1'b0;
  logic [31:0]     icache_rdata = '0;
  logic            ds_allowin = 1'b1;
  logic            fs_to_ds_valid;
  fs_to_ds_bus_t   fs_to_ds_bus;

  if_stage #(.DISCARD_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .pfs_to_fs_bus (pfs_to_fs_bus),
    .fs_allowin    (fs_allowin),
    .fs_valid      (fs_valid),
    .pipeline_flush(pipeline_flush),
    .bpu_flush     (bpu_flush),
    .icache_data_ok(icache_data_ok),
    .icache_rdata  (icache_rdata),
    .ds_allowin    (ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus  (fs_to_ds_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every icache request in flight, oldest first; live=0 once a flush killed it.
  typedef struct {
    logic [31:0] data;
    bit          live;
    int          rdy;
  } ic_t;
  ic_t ic_q[$];

  // Bundles accepted by fetch and not yet handed to decode.
  typedef struct {
    logic [31:0] pc;
    logic        br;
    exception_t  exc;
    logic [31:0] data;
    bit          got;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] req_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic drive_pfs(input bit pv, input bit rs, input bit ex, input logic [31:0] pc,
                           input logic [31:0] data, input bit br);
    pfs_to_fs_bus = '0;
    req_data = data;
    if (pv) begin
      pfs_to_fs_bus.valid    = 1'b1;
      pfs_to_fs_bus.req_sent = rs;
      pfs_to_fs_bus.br_op    = br;
      pfs_to_fs_bus.pc       = pc;
      if (ex) begin
        pfs_to_fs_bus.exception.ex       = 1'b1;
        pfs_to_fs_bus.exception.exccode  = EXC_ADEL;
        pfs_to_fs_bus.exception.badvaddr = pc;
      end
      if (rs) ic_q.push_back('{data: data, live: 1'b1, rdy: cyc + 1});
    end
  endtask

  task automatic step(input bit fl_ex, input bit fl_bpu, input bit ds, input bit ok,
                      input bit pv, input bit rs, input bit ex,
                      input logic [31:0] pc, input logic [31:0] data);
    @(posedge clk); #1;
    pipeline_flush    = '0;
    pipeline_flush.ex = fl_ex;
    bpu_flush         = fl_bpu;
    ds_allowin        = ds;
    icache_data_ok    = ok && (ic_q.size() != 0);
    icache_rdata      = icache_data_ok ? ic_q[0].data : $urandom;
    #1;
    drive_pfs(pv, rs, ex, pc, data, 1'b0);
  endtask

  task automatic idle(input bit ds);
    step(1'b0, 1'b0, ds, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Reference model: one compare-and-update pass per cycle, on the falling edge.
  bit   m_fl, m_has, m_resp_live, m_ready, m_valid, m_allow;
  exp_t m_e;
  ic_t  m_i;
  always @(negedge clk) begin
    if (reset) begin
      ic_q.delete();
      exp_q.delete();
      chk("reset_fs_valid", 64'(fs_valid), 64'd0);
      chk("reset_to_ds_valid", 64'(fs_to_ds_valid), 64'd0);
    end else begin
      m_fl = pipeline_flush.ex | pipeline_flush.eret | pipeline_flush.tlb_op |
             pipeline_flush.cache_op | bpu_flush;
      m_has       = exp_q.size() != 0;
      m_resp_live = icache_data_ok && ic_q.size() != 0 && ic_q[0].live;
      m_ready     = m_has && (exp_q[0].exc.ex || exp_q[0].got || m_resp_live);
      m_valid     = m_ready && !m_fl;
      m_allow     = !m_has || (m_ready && ds_allowin);

      chk("fs_valid", 64'(fs_valid), 64'(m_has));
      chk("fs_to_ds_valid", 64'(fs_to_ds_valid), 64'(m_valid));
      chk("fs_allowin", 64'(fs_allowin), 64'(m_allow));
      if (m_valid && fs_to_ds_valid) begin
        chk("bus_pc", 64'(fs_to_ds_bus.pc), 64'(exp_q[0].pc));
        chk("bus_inst", 64'(fs_to_ds_bus.inst), exp_q[0].exc.ex ? 64'd0 : 64'(exp_q[0].data));
        chk("bus_br_op", 64'(fs_to_ds_bus.br_op), 64'(exp_q[0].br));
        chk("bus_exception", 64'(fs_to_ds_bus.exception), 64'(exp_q[0].exc));
      end

      if (icache_data_ok && ic_q.size() != 0) begin
        if (ic_q[0].live && !m_fl && m_has) begin
          m_e = exp_q[0];
          m_e.got = 1'b1;
          exp_q[0] = m_e;
        end
        void'(ic_q.pop_front());
      end
      if (m_valid && ds_allowin) void'(exp_q.pop_front());
      if (m_fl) begin
        exp_q.delete();
        for (int i = 0; i < ic_q.size(); i++) begin
          m_i = ic_q[i];
          m_i.live = 1'b0;
          ic_q[i] = m_i;
        end
      end
      if (pfs_to_fs_bus.valid && m_allow && !m_fl)
        exp_q.push_back('{pc: pfs_to_fs_bus.pc, br: pfs_to_fs_bus.br_op,
                          exc: pfs_to_fs_bus.exception, data: req_data, got: 1'b0});
    end
  end

  logic [31:0] r_pc;
  int          r;
  bit          r_ok;

  initial begin
    @(posedge clk); #3;
    chk("reset_inst_buf_valid", 64'(dut.inst_buf_valid_q), 64'd0);
    chk("reset_discard_cnt", 64'(dut.discard_cnt_q), 64'd0);
    reset = 1'b0;

    // Steady hit stream: three bundles on three consecutive cycles.
    step(0, 0, 1, 0, 1, 1, 0, 32'hbfc00000, 32'h11110000);
    step(0, 0, 1, 1, 1, 1, 0, 32'hbfc00004, 32'h11110004);
    @(negedge clk);
    chk("hit0_valid", 64'(fs_to_ds_valid), 64'd1);
    chk("hit0_inst", 64'(fs_to_ds_bus.inst), 64'h11110000);
    step(0, 0, 1, 1, 1, 1, 0, 32'hbfc00008, 32'h11110008);
    @(negedge clk);
    chk("hit1_pc", 64'(fs_to_ds_bus.pc), 64'hbfc00004);
    chk("hit1_inst", 64'(fs_to_ds_bus.inst), 64'h11110004);
    step(0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("hit2_valid", 64'(fs_to_ds_valid), 64'd1);
    chk("hit2_inst", 64'(fs_to_ds_bus.inst), 64'h11110008);
    idle(1);

    // Decode stall: beat is buffered and handed over exactly once.
    step(0, 0, 1, 0, 1, 1, 0, 32'hbfc00020, 32'h24080001);
    step(0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("stall_allowin", 64'(fs_allowin), 64'd0);
    idle(0);
    idle(0);
    @(negedge clk);
    chk("stall_buf_valid", 64'(dut.inst_buf_valid_q), 64'd1);
    chk("stall_buf_inst", 64'(fs_to_ds_bus.inst), 64'h24080001);
    idle(1);
    @(negedge clk);
    chk("stall_release_inst", 64'(fs_to_ds_bus.inst), 64'h24080001);
    idle(1);
    @(negedge clk);
    chk("stall_delivered_once", 64'(fs_to_ds_valid), 64'd0);

    // Flush while waiting: one stale beat is swallowed.
    step(0, 0, 1, 0, 1, 1, 0, 32'hbfc00010, 32'h33330010);
    idle(1);
    step(1, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    idle(1);
    @(negedge clk);
    chk("flush_wait_cnt1", 64'(dut.discard_cnt_q), 64'd1);
    step(0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("flush_wait_dropped", 64'(fs_to_ds_valid), 64'd0);
    idle(1);
    @(negedge clk);
    chk("flush_wait_cnt0", 64'(dut.discard_cnt_q), 64'd0);

    // Two killed requests in flight, then a live one for 0xbfc00380.
    step(0, 0, 1, 0, 1, 1, 0, 32'hbfc00030, 32'h44440030);
    step(1, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 1, 1, 0, 1, 1, 0, 32'hbfc00040, 32'h44440040);
    step(0, 0, 1, 0, 1, 1, 0, 32'hbfc00380, 32'h44440380);
    @(negedge clk);
    chk("two_kill_cnt2", 64'(dut.discard_cnt_q), 64'd2);
    step(0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("two_kill_drop1", 64'(fs_to_ds_valid), 64'd0);
    step(0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("two_kill_drop2", 64'(fs_to_ds_valid), 64'd0);
    step(0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("two_kill_deliver_pc", 64'(fs_to_ds_bus.pc), 64'hbfc00380);
    chk("two_kill_deliver_inst", 64'(fs_to_ds_bus.inst), 64'h44440380);
    idle(1);

    // Address-error bundle passes straight through with a zero word.
    step(0, 0, 1, 0, 1, 0, 1, 32'hbfc00002, 32'h0);
    idle(1);
    @(negedge clk);
    chk("exc_valid", 64'(fs_to_ds_valid), 64'd1);
    chk("exc_inst", 64'(fs_to_ds_bus.inst), 64'd0);
    chk("exc_record", 64'(fs_to_ds_bus.exception), {26'd0, 1'b1, EXC_ADEL, 32'hbfc00002});
    idle(1);

    // Asynchronous reset in the middle of a decode stall.
    step(0, 0, 1, 0, 1, 1, 0, 32'hbfc00050, 32'h55550050);
    step(0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    idle(0);
    @(negedge clk);
    chk("pre_reset_buf_valid", 64'(dut.inst_buf_valid_q), 64'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_fs_valid", 64'(fs_valid), 64'd0);
    chk("async_to_ds_valid", 64'(fs_to_ds_valid), 64'd0);
    chk("async_buf_valid", 64'(dut.inst_buf_valid_q), 64'd0);
    chk("async_discard_cnt", 64'(dut.discard_cnt_q), 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;

    // Random traffic against the model.
    repeat (3000) begin
      @(posedge clk); #1;
      r = int'($urandom_range(0, 31));
      pipeline_flush          = '0;
      pipeline_flush.ex       = (r == 0);
      pipeline_flush.eret     = (r == 1);
      pipeline_flush.tlb_op   = (r == 2);
      pipeline_flush.cache_op = (r == 3);
      bpu_flush               = (r == 4);
      ds_allowin     = ($urandom_range(0, 3) != 0);
      r_ok           = (ic_q.size() != 0) && (ic_q[0].rdy <= cyc) && ($urandom_range(0, 2) != 0);
      icache_data_ok = r_ok;
      icache_rdata   = r_ok ? ic_q[0].data : $urandom;
      #1;
      r_pc = $urandom;
      r_pc[1:0] = 2'b00;
      if (fs_allowin && $urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 9) == 0)
          drive_pfs(1'b1, 1'b0, 1'b1, r_pc, 32'h0, 1'($urandom_range(0, 1)));
        else if (ic_q.size() <= 2)
          drive_pfs(1'b1, 1'b1, 1'b0, r_pc, $urandom, 1'($urandom_range(0, 1)));
        else
          drive_pfs(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      end else begin
        drive_pfs(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      end
    end
    repeat (3) idle(1);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
